simmem_wresp_delay_buffer: RTL

- Holds AXI write responses (simmem_pkg::write_resp_t) coming back from the real memory controller and releases each one to the requester-side B channel only after a fixed latency.
- Sits directly downstream of the memory-side B channel and upstream of the requester-side B port.
- Each response is released in arrival order, never earlier than DelayCycles cycles after it was accepted.

---
 rtl/simmem_pkg.sv | 15 +
 rtl/simmem_wresp_delay_buffer.sv | 105 ++++++++++
 2 files changed

// File: rtl/simmem_pkg.sv
// Shared types for the simulated-memory write-response path.
package simmem_pkg;

    localparam int unsigned IdW   = 8;
    localparam int unsigned RespW = 2;
    localparam int unsigned UserW = 4;

    // AXI B-channel payload carried opaquely through the delay buffer
    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [RespW-1:0] response;
        logic [UserW-1:0] user_signal;
    } write_resp_t;

endpackage

// File: rtl/simmem_wresp_delay_buffer.sv
// Delays each AXI write response by a fixed number of cycles before
// presenting it on the requester-side B channel, in strict arrival order.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/in_ready_o   memory-side B handshake, in_resp_i payload
//   out_valid_o/out_ready_i requester-side B handshake, out_resp_o payload
//   occupancy_o             number of stored responses
module simmem_wresp_delay_buffer #(
    parameter int unsigned Depth       = 8,
    parameter int unsigned DelayCycles = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  simmem_pkg::write_resp_t  in_resp_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output simmem_pkg::write_resp_t  out_resp_o,
    output logic [$clog2(Depth):0]   occupancy_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;
    // A single-cycle delay needs no countdown range, but keep one bit so the
    // storage stays well-formed; the load value is then always 0.
    localparam int unsigned CntW = (DelayCycles > 1) ? $clog2(DelayCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DelayCycles - 1);

    simmem_pkg::write_resp_t payload_q [Depth];
    simmem_pkg::write_resp_t payload_d [Depth];
    logic [CntW-1:0]         cnt_q     [Depth];
    logic [CntW-1:0]         cnt_d     [Depth];
    logic [Depth-1:0]        valid_q, valid_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;

    logic [IdxW-1:0] wr_idx, rd_idx;
    logic            empty, full, push, pop;

    // Pointer status, wrap bit in the MSB
    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);

    // Output view derived from registered state only
    assign in_ready_o  = !full;
    assign out_valid_o = !empty && (cnt_q[rd_idx] == '0);
    assign out_resp_o  = empty ? '0 : payload_q[rd_idx];
    assign occupancy_o = wr_ptr_q - rd_ptr_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    // Next-state: age all live entries, then apply pop and push
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;

        // Countdowns saturate at 0 so a blocked head keeps its maturity
        for (int i = 0; i < int'(Depth); i++) begin
            if (valid_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end

        if (pop) begin
            valid_d[rd_idx] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PtrW'(1);
        end

        // A push never targets the popped slot: that would require full
        if (push) begin
            payload_d[wr_idx] = in_resp_i;
            cnt_d[wr_idx]     = CntLoad;
            valid_d[wr_idx]   = 1'b1;
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                cnt_q[i]     <= '0;
                payload_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
        end
    end

endmodule
